gem_cluster_xlt_sched: RTL and testbench

//  Per-BX scheduler for the single GEM-cluster -> CSC wire/xky translator. Latches NCLST GEM

---
 rtl/gem_cluster_xlt_sched_pkg.sv | 42 ++++
 rtl/gem_cluster_xlt_sched_if.sv | 47 ++++
 rtl/gem_slot_prio_enc.sv | 31 +++
 rtl/gem_cluster_xlt_sched.sv | 208 ++++++++++++++++++++
 tb/tb_gem_cluster_xlt_sched.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gem_cluster_xlt_sched_pkg.sv
// ---------------------------------------------------------------------------
// gem_cluster_xlt_sched_pkg
//   Shared constants and types for the GEM-cluster -> CSC translator scheduler.
//   Holds the per-BX slot count, translator window field widths, the bit
//   layout of a 14-bit GEM cluster word {size[2:0], roll[2:0], pad[7:0]},
//   the scheduler FSM state encoding and a saturating-increment helper for
//   the dropped-strobe counter.
// ---------------------------------------------------------------------------
package gem_cluster_xlt_sched_pkg;

   localparam int NCLST    = 8;
   localparam int SLOTB    = 3;
   localparam int WIREBITS = 7;
   localparam int MXXKYB   = 10;

   localparam int CLWORDB  = 14;
   localparam int PAD_LSB  = 0;
   localparam int PAD_W    = 8;
   localparam int ROLL_LSB = 8;
   localparam int ROLL_W   = 3;
   localparam int SIZE_LSB = 11;
   localparam int SIZE_W   = 3;

   localparam int OVFB     = 8;

   typedef logic [CLWORDB-1:0] clusterWord_t;

   // IDLE waits for a strobe; the latch of a new BX happens on the transition
   // out of IDLE or DONE, so there is no separate LATCH cycle.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } schedState_t;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [OVFB-1:0] satInc(input logic [OVFB-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/gem_cluster_xlt_sched_if.sv
// ---------------------------------------------------------------------------
// gem_cluster_xlt_sched_if
//   Bundle between the scheduler and the external cluster translator.
//   Issue side (scheduler -> translator):
//     xlt_cluster  14-bit cluster word, zero on non-issue clocks
//     xlt_vpf      issue strobe
//     xlt_roll/xlt_pad/xlt_size  field slices of xlt_cluster
//   Return side (translator -> scheduler), valid XLT_LAT clocks after issue:
//     xlt_wire_lo/hi/mi  wiregroup window
//     xlt_xky_lo/hi/mi   1/8-strip key window
//     xlt_me1a           ME1a flag
//     xlt_vpf_ret        registered vpf, 0 means matching disabled
//   Modports: master = scheduler, slave = translator.
// ---------------------------------------------------------------------------
interface gem_cluster_xlt_sched_if;
   import gem_cluster_xlt_sched_pkg::*;

   logic [CLWORDB-1:0]  xlt_cluster;
   logic                xlt_vpf;
   logic [ROLL_W-1:0]   xlt_roll;
   logic [PAD_W-1:0]    xlt_pad;
   logic [SIZE_W-1:0]   xlt_size;

   logic [WIREBITS-1:0] xlt_wire_lo;
   logic [WIREBITS-1:0] xlt_wire_hi;
   logic [WIREBITS-1:0] xlt_wire_mi;
   logic [MXXKYB-1:0]   xlt_xky_lo;
   logic [MXXKYB-1:0]   xlt_xky_hi;
   logic [MXXKYB-1:0]   xlt_xky_mi;
   logic                xlt_me1a;
   logic                xlt_vpf_ret;

   modport master (
      output xlt_cluster, xlt_vpf, xlt_roll, xlt_pad, xlt_size,
      input  xlt_wire_lo, xlt_wire_hi, xlt_wire_mi,
      input  xlt_xky_lo, xlt_xky_hi, xlt_xky_mi,
      input  xlt_me1a, xlt_vpf_ret
   );

   modport slave (
      input  xlt_cluster, xlt_vpf, xlt_roll, xlt_pad, xlt_size,
      output xlt_wire_lo, xlt_wire_hi, xlt_wire_mi,
      output xlt_xky_lo, xlt_xky_hi, xlt_xky_mi,
      output xlt_me1a, xlt_vpf_ret
   );

endinterface

// File: rtl/gem_slot_prio_enc.sv
// ---------------------------------------------------------------------------
// gem_slot_prio_enc
//   Lowest-index priority encoder over the pending-slot mask.
//   Ports:
//     mask_i  N-bit request mask
//     idx_o   index of the lowest set bit (0 when mask_i is empty)
//     any_o   at least one bit of mask_i is set
// ---------------------------------------------------------------------------
module gem_slot_prio_enc #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] mask_i,
   output logic [W-1:0] idx_o,
   output logic         any_o
);

   // Scan from the top down so the last hit, and therefore the winner, is
   // the lowest set bit.
   always_comb begin
      idx_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            idx_o = W'(i);
         end
      end
   end

   assign any_o = |mask_i;

endmodule

// File: rtl/gem_cluster_xlt_sched.sv
// ---------------------------------------------------------------------------
// gem_cluster_xlt_sched
//   Per-BX scheduler for the single GEM-cluster -> CSC wire/xky translator.
//   Latches NCLST clusters on bx_strobe, issues the valid ones one per clock
//   in ascending slot order, tracks each issue through an XLT_LAT-deep tag
//   pipe, stores the returned windows into a per-slot result bank and then
//   pulses done.
//   Ports:
//     clock, reset_n     clock and synchronous active-low reset
//     bx_strobe          1-clock pulse qualifying clusters_in / vpf_in
//     clusters_in        NCLST packed 14-bit cluster words, slot k at [14k+:14]
//     vpf_in             per-slot valid
//     xlt                translator bundle (master side)
//     res_wire/res_xky   per-slot {mi,hi,lo} windows
//     res_me1a           per-slot ME1a flag
//     res_valid          slot holds a translated, enabled cluster
//     done               1-clock pulse when the result bank is complete
//     busy               high from an accepted strobe until done
//     overflow_cnt       saturating count of strobes dropped while busy
// ---------------------------------------------------------------------------
module gem_cluster_xlt_sched
   import gem_cluster_xlt_sched_pkg::*;
#(
   parameter int XLT_LAT = 1
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic                            bx_strobe,
   input  logic [CLWORDB*NCLST-1:0]        clusters_in,
   input  logic [NCLST-1:0]                vpf_in,
   gem_cluster_xlt_sched_if.master         xlt,
   output logic [3*WIREBITS*NCLST-1:0]     res_wire,
   output logic [3*MXXKYB*NCLST-1:0]       res_xky,
   output logic [NCLST-1:0]                res_me1a,
   output logic [NCLST-1:0]                res_valid,
   output logic                            done,
   output logic                            busy,
   output logic [OVFB-1:0]                 overflow_cnt
);

   localparam logic [2:0] DRAIN_INIT = 3'(XLT_LAT);

   schedState_t                      state_q, state_d;
   logic [NCLST-1:0]                 pending_q, pending_d;
   logic [2:0]                       drainCnt_q, drainCnt_d;
   logic [NCLST-1:0][CLWORDB-1:0]    clusters_q;

   logic [SLOTB-1:0]                 issueSlot;
   logic                             pendingAny;
   logic                             issue;
   logic                             accept;
   logic                             drop;

   logic [XLT_LAT-1:0]               tagVld_q;
   logic [XLT_LAT-1:0][SLOTB-1:0]    tagSlot_q;
   logic                             tagExitVld;
   logic [SLOTB-1:0]                 tagExitSlot;

   logic [NCLST-1:0][3*WIREBITS-1:0] resWire_q;
   logic [NCLST-1:0][3*MXXKYB-1:0]   resXky_q;
   logic [NCLST-1:0]                 resMe1a_q;
   logic [NCLST-1:0]                 resValid_q;
   logic [OVFB-1:0]                  overflow_q;

   gem_slot_prio_enc #(
      .N (NCLST),
      .W (SLOTB)
   ) u_prio (
      .mask_i (pending_q),
      .idx_o  (issueSlot),
      .any_o  (pendingAny)
   );

   // Next-state logic. A strobe seen in IDLE or DONE starts a new BX: the
   // valid mask becomes the pending set and the FSM goes to ISSUE, or
   // straight to DRAIN when nothing is valid. DRAIN always lasts XLT_LAT+1
   // clocks, which covers the last tag leaving the pipe and its result
   // being written before done is raised. Strobes in ISSUE/DRAIN are dropped.
   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      drainCnt_d = drainCnt_q;
      issue      = 1'b0;
      accept     = 1'b0;
      drop       = 1'b0;

      case (state_q)
         S_IDLE: begin
            accept = bx_strobe;
         end
         S_ISSUE: begin
            drop = bx_strobe;
            if (pendingAny) begin
               issue     = 1'b1;
               pending_d = pending_q & ~(NCLST'(1) << issueSlot);
            end
            if (pending_d == '0) begin
               state_d    = S_DRAIN;
               drainCnt_d = DRAIN_INIT;
            end
         end
         S_DRAIN: begin
            drop = bx_strobe;
            if (drainCnt_q == 3'd0) begin
               state_d = S_DONE;
            end else begin
               drainCnt_d = drainCnt_q - 3'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            accept  = bx_strobe;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (accept) begin
         pending_d  = vpf_in;
         drainCnt_d = DRAIN_INIT;
         state_d    = (vpf_in != '0) ? S_ISSUE : S_DRAIN;
      end
   end

   // FSM state, pending mask and drain counter.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         pending_q  <= '0;
         drainCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         drainCnt_q <= drainCnt_d;
      end
   end

   // Cluster words are held for the whole BX so issue can pick any slot.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         clusters_q <= '0;
      end else if (accept) begin
         clusters_q <= clusters_in;
      end
   end

   // Tag pipe: each issue pushes {valid,slot}; the entry leaving the last
   // stage lines up with the translator's registered result for that slot.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         tagVld_q  <= '0;
         tagSlot_q <= '0;
      end else begin
         for (int i = XLT_LAT - 1; i > 0; i--) begin
            tagVld_q[i]  <= tagVld_q[i-1];
            tagSlot_q[i] <= tagSlot_q[i-1];
         end
         tagVld_q[0]  <= issue;
         tagSlot_q[0] <= issueSlot;
      end
   end

   assign tagExitVld  = tagVld_q[XLT_LAT-1];
   assign tagExitSlot = tagSlot_q[XLT_LAT-1];

   // Result bank. Validity is cleared when a new BX is accepted; window data
   // is simply overwritten per slot as results come back.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         resWire_q  <= '0;
         resXky_q   <= '0;
         resMe1a_q  <= '0;
         resValid_q <= '0;
      end else if (accept) begin
         resValid_q <= '0;
      end else if (tagExitVld) begin
         resWire_q[tagExitSlot]  <= {xlt.xlt_wire_mi, xlt.xlt_wire_hi, xlt.xlt_wire_lo};
         resXky_q[tagExitSlot]   <= {xlt.xlt_xky_mi, xlt.xlt_xky_hi, xlt.xlt_xky_lo};
         resMe1a_q[tagExitSlot]  <= xlt.xlt_me1a;
         resValid_q[tagExitSlot] <= xlt.xlt_vpf_ret;
      end
   end

   // Dropped-strobe counter; only reset clears it.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         overflow_q <= '0;
      end else if (drop) begin
         overflow_q <= satInc(overflow_q);
      end
   end

   assign xlt.xlt_vpf     = issue;
   assign xlt.xlt_cluster = issue ? clusters_q[issueSlot] : '0;
   assign xlt.xlt_pad     = xlt.xlt_cluster[PAD_LSB +: PAD_W];
   assign xlt.xlt_roll    = xlt.xlt_cluster[ROLL_LSB +: ROLL_W];
   assign xlt.xlt_size    = xlt.xlt_cluster[SIZE_LSB +: SIZE_W];

   assign res_wire     = resWire_q;
   assign res_xky      = resXky_q;
   assign res_me1a     = resMe1a_q;
   assign res_valid    = resValid_q;
   assign done         = (state_q == S_DONE);
   assign busy         = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign overflow_cnt = overflow_q;

endmodule

// File: tb/tb_gem_cluster_xlt_sched.sv
// ---------------------------------------------------------------------------
// tb_gem_cluster_xlt_sched
//   Directed bench for the GEM cluster translator scheduler with XLT_LAT=1.
//   A registered translator model answers each issue one clock later with
//   windows derived from the cluster word, so results can be predicted per
//   slot. Cycle c counts clocks after the edge that sampled bx_strobe.
// ---------------------------------------------------------------------------
module tb_gem_cluster_xlt_sched;
   import gem_cluster_xlt_sched_pkg::*;

   localparam int LAT = 1;

   logic                        clock = 1'b0;
   logic                        reset_n = 1'b0;
   logic                        bx_strobe = 1'b0;
   logic [CLWORDB*NCLST-1:0]    clusters_in = '0;
   logic [NCLST-1:0]            vpf_in = '0;
   logic [3*WIREBITS*NCLST-1:0] res_wire;
   logic [3*MXXKYB*NCLST-1:0]   res_xky;
   logic [NCLST-1:0]            res_me1a;
   logic [NCLST-1:0]            res_valid;
   logic                        done;
   logic                        busy;
   logic [OVFB-1:0]             overflow_cnt;

   int total = 0;
   int bad   = 0;

   logic [CLWORDB-1:0] clw [NCLST];
   logic               killEn = 1'b0;
   logic [7:0]         killPad = 8'h00;

   gem_cluster_xlt_sched_if xif ();

   gem_cluster_xlt_sched #(.XLT_LAT(LAT)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .bx_strobe    (bx_strobe),
      .clusters_in  (clusters_in),
      .vpf_in       (vpf_in),
      .xlt          (xif),
      .res_wire     (res_wire),
      .res_xky      (res_xky),
      .res_me1a     (res_me1a),
      .res_valid    (res_valid),
      .done         (done),
      .busy         (busy),
      .overflow_cnt (overflow_cnt)
   );

   always #5 clock = ~clock;

   // Translator windows as a function of the cluster word.
   function automatic logic [3*WIREBITS-1:0] expWire(input logic [13:0] w);
      return {{w[13:11], w[10:8], 1'b1}, w[6:0] ^ 7'h7F, w[6:0]};
   endfunction

   function automatic logic [3*MXXKYB-1:0] expXky(input logic [13:0] w);
      return {{1'b1, w[13:11], w[10:8], 3'b000}, {w[7:0], 2'b11}, {2'b00, w[7:0]}};
   endfunction

   function automatic int popc(input logic [7:0] m);
      int n = 0;
      for (int i = 0; i < 8; i++) if (m[i]) n++;
      return n;
   endfunction

   function automatic int nthSlot(input logic [7:0] m, input int n);
      int k = 0;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) begin
            if (k == n) return i;
            k++;
         end
      end
      return -1;
   endfunction

   // Registered translator model, one clock of latency.
   always @(posedge clock) begin
      {xif.xlt_wire_mi, xif.xlt_wire_hi, xif.xlt_wire_lo} <= expWire(xif.xlt_cluster);
      {xif.xlt_xky_mi, xif.xlt_xky_hi, xif.xlt_xky_lo}    <= expXky(xif.xlt_cluster);
      xif.xlt_me1a    <= xif.xlt_cluster[8];
      xif.xlt_vpf_ret <= xif.xlt_vpf && !(killEn && (xif.xlt_cluster[7:0] == killPad));
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Present a BX for one clock; returns in cycle 1.
   task automatic applyStimulus(input logic [7:0] mask);
      vpf_in    = mask;
      bx_strobe = 1'b1;
      tick();
      bx_strobe = 1'b0;
   endtask

   task automatic test_reset;
      reset_n   = 1'b0;
      bx_strobe = 1'b0;
      vpf_in    = '0;
      repeat (2) tick();
      total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      total++; if (xif.xlt_vpf !== 1'b0) begin bad++; $display("[TB] FAIL reset_vpf: got %b want 0", xif.xlt_vpf); end
      total++; if (xif.xlt_cluster !== 14'h0) begin bad++; $display("[TB] FAIL reset_cluster: got %h want 0", xif.xlt_cluster); end
      total++; if (res_valid !== 8'h00) begin bad++; $display("[TB] FAIL reset_res_valid: got %h want 00", res_valid); end
      total++; if (overflow_cnt !== 8'h00) begin bad++; $display("[TB] FAIL reset_overflow: got %0d want 0", overflow_cnt); end
      total++; if (res_wire !== '0) begin bad++; $display("[TB] FAIL reset_res_wire: got %h want 0", res_wire); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_sparse;
      logic [7:0] m = 8'hA1;
      int doneC = popc(m) + LAT + 2;
      applyStimulus(m);
      for (int c = 1; c <= doneC + 1; c++) begin
         int s = (c <= popc(m)) ? nthSlot(m, c - 1) : -1;
         logic [13:0] expCl = 14'h0;
         if (s >= 0) expCl = clw[s];
         total++; if (xif.xlt_vpf !== (s >= 0)) begin bad++; $display("[TB] FAIL sparse_vpf c=%0d: got %b want %b", c, xif.xlt_vpf, s >= 0); end
         total++; if (xif.xlt_cluster !== expCl) begin bad++; $display("[TB] FAIL sparse_cluster c=%0d: got %h want %h", c, xif.xlt_cluster, expCl); end
         total++; if (done !== (c == doneC)) begin bad++; $display("[TB] FAIL sparse_done c=%0d: got %b want %b", c, done, c == doneC); end
         total++; if (busy !== (c < doneC)) begin bad++; $display("[TB] FAIL sparse_busy c=%0d: got %b want %b", c, busy, c < doneC); end
         if (c == 2) begin
            total++; if (xif.xlt_pad !== 8'h65) begin bad++; $display("[TB] FAIL sparse_pad: got %h want 65", xif.xlt_pad); end
            total++; if (xif.xlt_roll !== 3'd2) begin bad++; $display("[TB] FAIL sparse_roll: got %0d want 2", xif.xlt_roll); end
            total++; if (xif.xlt_size !== 3'd5) begin bad++; $display("[TB] FAIL sparse_size: got %0d want 5", xif.xlt_size); end
         end
         tick();
      end
      total++; if (res_valid !== 8'hA1) begin bad++; $display("[TB] FAIL sparse_res_valid: got %h want a1", res_valid); end
      for (int k = 0; k < 8; k++) begin
         if (m[k]) begin
            total++; if (res_wire[k*3*WIREBITS +: 3*WIREBITS] !== expWire(clw[k])) begin bad++; $display("[TB] FAIL sparse_wire slot=%0d: got %h want %h", k, res_wire[k*3*WIREBITS +: 3*WIREBITS], expWire(clw[k])); end
            total++; if (res_xky[k*3*MXXKYB +: 3*MXXKYB] !== expXky(clw[k])) begin bad++; $display("[TB] FAIL sparse_xky slot=%0d: got %h want %h", k, res_xky[k*3*MXXKYB +: 3*MXXKYB], expXky(clw[k])); end
            total++; if (res_me1a[k] !== clw[k][8]) begin bad++; $display("[TB] FAIL sparse_me1a slot=%0d: got %b want %b", k, res_me1a[k], clw[k][8]); end
         end
      end
   endtask

   task automatic test_empty;
      applyStimulus(8'h00);
      for (int c = 1; c <= 4; c++) begin
         total++; if (xif.xlt_vpf !== 1'b0) begin bad++; $display("[TB] FAIL empty_vpf c=%0d: got %b want 0", c, xif.xlt_vpf); end
         total++; if (done !== (c == 3)) begin bad++; $display("[TB] FAIL empty_done c=%0d: got %b want %b", c, done, c == 3); end
         total++; if (busy !== (c < 3)) begin bad++; $display("[TB] FAIL empty_busy c=%0d: got %b want %b", c, busy, c < 3); end
         tick();
      end
      total++; if (res_valid !== 8'h00) begin bad++; $display("[TB] FAIL empty_res_valid: got %h want 00", res_valid); end
   endtask

   task automatic test_overflow;
      applyStimulus(8'hFF);
      for (int c = 1; c <= 12; c++) begin
         logic [13:0] expCl = 14'h0;
         if (c <= 8) expCl = clw[c-1];
         if (c == 2) begin
            bx_strobe = 1'b1;
            vpf_in    = 8'h01;
         end
         total++; if (xif.xlt_vpf !== (c <= 8)) begin bad++; $display("[TB] FAIL ovf_vpf c=%0d: got %b want %b", c, xif.xlt_vpf, c <= 8); end
         total++; if (xif.xlt_cluster !== expCl) begin bad++; $display("[TB] FAIL ovf_cluster c=%0d: got %h want %h", c, xif.xlt_cluster, expCl); end
         total++; if (done !== (c == 11)) begin bad++; $display("[TB] FAIL ovf_done c=%0d: got %b want %b", c, done, c == 11); end
         tick();
         bx_strobe = 1'b0;
      end
      total++; if (overflow_cnt !== 8'd1) begin bad++; $display("[TB] FAIL ovf_count: got %0d want 1", overflow_cnt); end
      total++; if (res_valid !== 8'hFF) begin bad++; $display("[TB] FAIL ovf_res_valid: got %h want ff", res_valid); end
      total++; if (res_wire[6*3*WIREBITS +: 3*WIREBITS] !== expWire(clw[6])) begin bad++; $display("[TB] FAIL ovf_wire6: got %h want %h", res_wire[6*3*WIREBITS +: 3*WIREBITS], expWire(clw[6])); end
   endtask

   task automatic test_back_to_back;
      applyStimulus(8'h06);
      for (int c = 1; c <= 5; c++) begin
         total++; if (done !== (c == 5)) begin bad++; $display("[TB] FAIL b2b_done1 c=%0d: got %b want %b", c, done, c == 5); end
         if (c == 5) begin
            total++; if (res_valid !== 8'h06) begin bad++; $display("[TB] FAIL b2b_res_valid1: got %h want 06", res_valid); end
            vpf_in    = 8'h10;
            bx_strobe = 1'b1;
         end
         tick();
         bx_strobe = 1'b0;
      end
      for (int c = 1; c <= 5; c++) begin
         logic [13:0] expCl = 14'h0;
         if (c == 1) expCl = clw[4];
         total++; if (xif.xlt_vpf !== (c == 1)) begin bad++; $display("[TB] FAIL b2b_vpf c=%0d: got %b want %b", c, xif.xlt_vpf, c == 1); end
         total++; if (xif.xlt_cluster !== expCl) begin bad++; $display("[TB] FAIL b2b_cluster c=%0d: got %h want %h", c, xif.xlt_cluster, expCl); end
         total++; if (done !== (c == 4)) begin bad++; $display("[TB] FAIL b2b_done2 c=%0d: got %b want %b", c, done, c == 4); end
         tick();
      end
      total++; if (overflow_cnt !== 8'd1) begin bad++; $display("[TB] FAIL b2b_overflow: got %0d want 1", overflow_cnt); end
      total++; if (res_valid !== 8'h10) begin bad++; $display("[TB] FAIL b2b_res_valid2: got %h want 10", res_valid); end
      total++; if (res_xky[4*3*MXXKYB +: 3*MXXKYB] !== expXky(clw[4])) begin bad++; $display("[TB] FAIL b2b_xky4: got %h want %h", res_xky[4*3*MXXKYB +: 3*MXXKYB], expXky(clw[4])); end
   endtask

   task automatic test_ret_disable;
      killEn  = 1'b1;
      killPad = 8'h43;
      applyStimulus(8'hFF);
      for (int c = 1; c <= 12; c++) begin
         total++; if (done !== (c == 11)) begin bad++; $display("[TB] FAIL ret_done c=%0d: got %b want %b", c, done, c == 11); end
         tick();
      end
      killEn = 1'b0;
      total++; if (res_valid !== 8'hF7) begin bad++; $display("[TB] FAIL ret_res_valid: got %h want f7", res_valid); end
   endtask

   task automatic test_saturation;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      vpf_in    = 8'hFF;
      bx_strobe = 1'b1;
      repeat (33) tick();
      total++; if (overflow_cnt !== 8'd30) begin bad++; $display("[TB] FAIL sat_count30: got %0d want 30", overflow_cnt); end
      total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL sat_done_held: got %b want 1", done); end
      repeat (400) tick();
      total++; if (overflow_cnt !== 8'd255) begin bad++; $display("[TB] FAIL sat_count255: got %0d want 255", overflow_cnt); end
      bx_strobe = 1'b0;
      repeat (14) tick();
      total++; if (overflow_cnt !== 8'd255) begin bad++; $display("[TB] FAIL sat_hold: got %0d want 255", overflow_cnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL sat_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid;
      applyStimulus(8'hFF);
      tick();
      tick();
      total++; if (xif.xlt_cluster !== clw[2]) begin bad++; $display("[TB] FAIL rmid_issue: got %h want %h", xif.xlt_cluster, clw[2]); end
      reset_n = 1'b0;
      tick();
      total++; if (xif.xlt_vpf !== 1'b0) begin bad++; $display("[TB] FAIL rmid_vpf: got %b want 0", xif.xlt_vpf); end
      total++; if (xif.xlt_cluster !== 14'h0) begin bad++; $display("[TB] FAIL rmid_cluster: got %h want 0", xif.xlt_cluster); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rmid_busy: got %b want 0", busy); end
      total++; if (res_valid !== 8'h00) begin bad++; $display("[TB] FAIL rmid_res_valid: got %h want 00", res_valid); end
      total++; if (overflow_cnt !== 8'd0) begin bad++; $display("[TB] FAIL rmid_overflow: got %0d want 0", overflow_cnt); end
      reset_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL rmid_no_done c=%0d: got %b want 0", c, done); end
         tick();
      end
      applyStimulus(8'h81);
      for (int c = 1; c <= 6; c++) begin
         total++; if (xif.xlt_vpf !== (c <= 2)) begin bad++; $display("[TB] FAIL rmid_fresh_vpf c=%0d: got %b want %b", c, xif.xlt_vpf, c <= 2); end
         total++; if (done !== (c == 5)) begin bad++; $display("[TB] FAIL rmid_fresh_done c=%0d: got %b want %b", c, done, c == 5); end
         tick();
      end
      total++; if (res_valid !== 8'h81) begin bad++; $display("[TB] FAIL rmid_fresh_res_valid: got %h want 81", res_valid); end
   endtask

   initial begin
      for (int k = 0; k < NCLST; k++) begin
         clw[k] = {3'(k), 3'(7 - k), 8'(16 + 17 * k)};
         clusters_in[k*CLWORDB +: CLWORDB] = clw[k];
      end
      $display("[TB] start");
      test_reset();
      test_sparse();
      test_empty();
      test_overflow();
      test_back_to_back();
      test_ret_disable();
      test_saturation();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
